// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: screen defaults, SRAM widths, address packing
// and the writer FSM state type.
package fb_pkg;

  localparam int unsigned SCREEN_W_DEF = 640;
  localparam int unsigned SCREEN_H_DEF = 480;
  localparam int unsigned COORD_W      = 10;
  localparam int unsigned ADDR_W       = 20;
  localparam int unsigned DATA_W       = 16;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StWrite,
    StHold
  } wr_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } px_req_t;

  // SRAM word address layout: {page, y[8:0], x[9:0]}
  function automatic logic [ADDR_W-1:0] pack_addr(input logic       page,
                                                  input logic [8:0] y,
                                                  input logic [9:0] x);
    return {page, y, x};
  endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous pixel request FIFO with registered occupancy count.
module fb_wr_fifo #(
  parameter int unsigned Width = 36,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & ~full_o;
  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fb_writer.sv
// Framebuffer SRAM writer: queues pixel requests and page clears, and issues
// 3-cycle SETUP/WRITE/HOLD SRAM write cycles inside the vga-granted window.
module fb_writer
  import fb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SCREEN_W   = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H   = SCREEN_H_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        draw_en,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [9:0]  wr_x,
  input  logic [9:0]  wr_y,
  input  logic        wr_page,
  input  logic [15:0] wr_color,
  input  logic        clear_start,
  input  logic        clear_page,
  input  logic [15:0] clear_color,
  output logic        busy_out,
  output logic        oob_out,
  output logic        bus_own_out,
  output logic [19:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_UB_N
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [9:0]  XMax = 10'(SCREEN_W - 1);
  localparam logic [8:0]  YMax = 9'(SCREEN_H - 1);

  wr_state_e       state_q, state_d;
  logic            clr_q, clr_d;
  logic            clr_page_q;
  logic [15:0]     clr_color_q;
  logic [9:0]      clr_x_q, clr_x_d;
  logic [8:0]      clr_y_q, clr_y_d;
  logic            oob_q, oob_d;

  px_req_t         push_req, head_req;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_cnt;
  logic            accept, in_range, fifo_push, fifo_pop;
  logic            src_fifo, clr_adv, clr_last, clr_go, work_rem;
  logic [19:0]     cur_addr;
  logic [15:0]     cur_data;

  assign wr_ready  = ~rst & ~fifo_full & ~clr_q;
  assign accept    = wr_valid & wr_ready;
  assign in_range  = ({1'b0, wr_x} < 11'(SCREEN_W)) && ({1'b0, wr_y} < 11'(SCREEN_H));
  assign fifo_push = accept & in_range;
  assign push_req  = '{addr: pack_addr(wr_page, wr_y[8:0], wr_x), data: wr_color};

  fb_wr_fifo #(
    .Width($bits(px_req_t)),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_i  (rst),
    .push_i (fifo_push),
    .wdata_i(push_req),
    .pop_i  (fifo_pop),
    .rdata_o(head_req),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_cnt)
  );

  // Queued pixels always drain before a pending clear starts.
  assign src_fifo = ~fifo_empty;
  assign fifo_pop = (state_q == StHold) & src_fifo;
  assign clr_adv  = (state_q == StHold) & ~src_fifo & clr_q;
  assign clr_last = (clr_x_q == XMax) && (clr_y_q == YMax);
  assign clr_go   = clear_start & ~clr_q;
  assign oob_d    = oob_q | (accept & ~in_range);

  always_comb begin
    clr_d   = clr_q;
    clr_x_d = clr_x_q;
    clr_y_d = clr_y_q;
    if (clr_adv) begin
      if (clr_last) begin
        clr_d   = 1'b0;
        clr_x_d = '0;
        clr_y_d = '0;
      end else if (clr_x_q == XMax) begin
        clr_x_d = '0;
        clr_y_d = clr_y_q + 9'd1;
      end else begin
        clr_x_d = clr_x_q + 10'd1;
      end
    end else if (clr_go) begin
      clr_d   = 1'b1;
      clr_x_d = '0;
      clr_y_d = '0;
    end
  end

  assign work_rem = (fifo_cnt != CntW'(fifo_pop)) | fifo_push | clr_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (draw_en && (src_fifo || clr_q)) state_d = StSetup;
      StSetup: state_d = draw_en ? StWrite : StIdle;
      StWrite: state_d = StHold;
      StHold:  state_d = (draw_en && work_rem) ? StSetup : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      clr_q       <= 1'b0;
      clr_x_q     <= '0;
      clr_y_q     <= '0;
      clr_page_q  <= 1'b0;
      clr_color_q <= '0;
      oob_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      clr_x_q <= clr_x_d;
      clr_y_q <= clr_y_d;
      oob_q   <= oob_d;
      if (clr_go) begin
        clr_page_q  <= clear_page;
        clr_color_q <= clear_color;
      end
    end
  end

  // Source is stable from SETUP through HOLD; it only moves at the HOLD edge.
  assign cur_addr = src_fifo ? head_req.addr : pack_addr(clr_page_q, clr_y_q, clr_x_q);
  assign cur_data = src_fifo ? head_req.data : clr_color_q;

  assign bus_own_out = (state_q != StIdle);
  assign busy_out    = src_fifo | clr_q;
  assign oob_out     = oob_q;
  assign SRAM_ADDR   = bus_own_out ? cur_addr : '0;
  assign SRAM_DQ     = bus_own_out ? cur_data : 16'hzzzz;
  assign SRAM_CE_N   = ~bus_own_out;
  assign SRAM_LB_N   = ~bus_own_out;
  assign SRAM_UB_N   = ~bus_own_out;
  assign SRAM_OE_N   = 1'b1;
  assign SRAM_WE_N   = (state_q != StWrite);

endmodule

// File: tb/tb_fb_writer.sv
// Self-checking bench for fb_writer: directed scenarios plus randomized pixel
// traffic, compared against an ordered list of expected SRAM writes.
module tb_fb_writer;

  localparam int W = 32;
  localparam int H = 24;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        draw_en = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [9:0]  wr_x = '0;
  logic [9:0]  wr_y = '0;
  logic        wr_page = 1'b0;
  logic [15:0] wr_color = '0;
  logic        clear_start = 1'b0;
  logic        clear_page = 1'b0;
  logic [15:0] clear_color = '0;
  logic        busy_out, oob_out, bus_own_out;
  logic [19:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        sram_oe_n, sram_we_n, sram_ce_n, sram_lb_n, sram_ub_n;

  fb_writer #(
    .FIFO_DEPTH(D),
    .SCREEN_W  (W),
    .SCREEN_H  (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .draw_en    (draw_en),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_page    (wr_page),
    .wr_color   (wr_color),
    .clear_start(clear_start),
    .clear_page (clear_page),
    .clear_color(clear_color),
    .busy_out   (busy_out),
    .oob_out    (oob_out),
    .bus_own_out(bus_own_out),
    .SRAM_ADDR  (sram_addr),
    .SRAM_DQ    (sram_dq),
    .SRAM_OE_N  (sram_oe_n),
    .SRAM_WE_N  (sram_we_n),
    .SRAM_CE_N  (sram_ce_n),
    .SRAM_LB_N  (sram_lb_n),
    .SRAM_UB_N  (sram_ub_n)
  );

  always #5 clk = ~clk;

  logic [19:0] exp_addr[$];
  logic [15:0] exp_data[$];
  logic [19:0] obs_addr[$];
  logic [15:0] obs_data[$];
  int          own_cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          log_idx = 0;

  // SRAM side: every cycle with WE_N low commits one word.
  always @(negedge clk) begin
    if (sram_we_n == 1'b0) begin
      obs_addr.push_back(sram_addr);
      obs_data.push_back(sram_dq);
    end
    if (bus_own_out) own_cnt <= own_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got hang, want completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [19:0] px_addr(input int p, input int x, input int y);
    return 20'(p * 524288 + y * 1024 + x);
  endfunction

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_px(input int x, input int y, input int p, input logic [15:0] c,
                         input bit model);
    int t;
    t = 0;
    wr_x     = 10'(x);
    wr_y     = 10'(y);
    wr_page  = p[0];
    wr_color = c;
    wr_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (wr_ready) break;
      t++;
      if (t == 8) draw_en = 1'b1;
      if (t > 500) begin
        chk("push_timeout", 36'(wr_ready), 36'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    if (model && x < W && y < H) begin
      exp_addr.push_back(px_addr(p, x, y));
      exp_data.push_back(c);
    end
  endtask

  task automatic wait_idle(input int max);
    int t;
    t = 0;
    forever begin
      tick(1);
      if (!busy_out && !bus_own_out) break;
      t++;
      if (t > max) begin
        chk("wait_idle_timeout", 36'(busy_out), 36'd0);
        break;
      end
    end
  endtask

  task automatic check_log(input string tag);
    int n;
    chk($sformatf("%s_len", tag), 36'(obs_addr.size()), 36'(exp_addr.size()));
    n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = log_idx; i < n; i++)
      chk($sformatf("%s_wr%0d", tag, i), {obs_addr[i], obs_data[i]}, {exp_addr[i], exp_data[i]});
    log_idx = n;
  endtask

  initial begin
    int own0, n0, rx, ry, rp;
    logic [15:0] c;

    // Reset state
    tick(3);
    chk("rst_wr_ready", 36'(wr_ready), 36'd0);
    chk("rst_strobes", 36'({sram_oe_n, sram_we_n, sram_ce_n, sram_lb_n, sram_ub_n}), 36'h1f);
    chk("rst_addr", 36'(sram_addr), 36'd0);
    chk("rst_flags", 36'({busy_out, oob_out, bus_own_out}), 36'd0);
    rst = 1'b0;
    tick(1);
    chk("post_rst_wr_ready", 36'(wr_ready), 36'd1);

    // Single pixel with window open
    draw_en = 1'b1;
    own0 = own_cnt;
    push_px(10, 20, 0, 16'hF800, 1'b1);
    wait_idle(20);
    tick(2);
    chk("single_own_cycles", 36'(own_cnt - own0), 36'd3);
    chk("single_addr", 36'(obs_addr.size() > 0 ? obs_addr[0] : 20'hFFFFF), 36'h0500A);
    chk("single_idle_strobes", 36'({sram_we_n, sram_ce_n, bus_own_out}), 36'b110);
    check_log("single");

    // Fill FIFO with window closed, then drain at full rate
    draw_en = 1'b0;
    for (int i = 0; i < D; i++)
      push_px($urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom_range(0, 1),
              16'($urandom), 1'b1);
    tick(1);
    chk("full_wr_ready", 36'(wr_ready), 36'd0);
    chk("full_busy", 36'(busy_out), 36'd1);
    chk("full_no_write", 36'(obs_addr.size()), 36'(exp_addr.size() - D));
    own0 = own_cnt;
    draw_en = 1'b1;
    tick(13);
    chk("drain_own_cycles", 36'(own_cnt - own0), 36'd12);
    chk("drain_idle", 36'({busy_out, bus_own_out, wr_ready}), 36'b001);
    check_log("drain");
    push_px(3, 4, 1, 16'h1234, 1'b1);
    wait_idle(20);
    check_log("fifth");

    // Out-of-range pixels are dropped and latch oob_out
    chk("oob_before", 36'(oob_out), 36'd0);
    own0 = own_cnt;
    push_px(W, 0, 0, 16'hAAAA, 1'b1);
    chk("oob_set", 36'(oob_out), 36'd1);
    push_px(0, H, 1, 16'h5555, 1'b1);
    tick(4);
    chk("oob_no_bus", 36'(own_cnt - own0), 36'd0);
    chk("oob_sticky", 36'(oob_out), 36'd1);
    check_log("oob");

    // Window closes during SETUP: retried later
    draw_en = 1'b0;
    push_px(7, 9, 0, 16'h0F0F, 1'b1);
    own0 = own_cnt;
    n0 = obs_addr.size();
    draw_en = 1'b1;
    tick(1);
    draw_en = 1'b0;
    chk("abort_setup_own", 36'(bus_own_out), 36'd1);
    tick(3);
    chk("abort_no_write", 36'(obs_addr.size()), 36'(n0));
    chk("abort_own_cycles", 36'(own_cnt - own0), 36'd1);
    chk("abort_busy", 36'(busy_out), 36'd1);
    draw_en = 1'b1;
    wait_idle(20);
    check_log("retry");

    // Window closes during WRITE: cycle completes through HOLD
    draw_en = 1'b0;
    push_px(31, 23, 1, 16'hBEEF, 1'b1);
    draw_en = 1'b1;
    tick(2);
    chk("late_drop_we", 36'(sram_we_n), 36'd0);
    draw_en = 1'b0;
    tick(1);
    chk("late_drop_hold", 36'({bus_own_out, sram_we_n}), 36'b11);
    tick(2);
    chk("late_drop_idle", 36'({busy_out, bus_own_out}), 36'd0);
    check_log("late_drop");

    // Random traffic with a wavering grant
    for (int i = 0; i < 40; i++) begin
      draw_en = ($urandom_range(0, 3) != 0);
      rx = $urandom_range(0, W);
      ry = $urandom_range(0, H);
      rp = $urandom_range(0, 1);
      push_px(rx, ry, rp, 16'($urandom), 1'b1);
      repeat ($urandom_range(0, 3)) begin
        draw_en = $urandom_range(0, 1) != 0;
        tick(1);
      end
    end
    draw_en = 1'b1;
    wait_idle(500);
    check_log("random");

    // Page clear behind two queued pixels
    draw_en = 1'b0;
    push_px(1, 2, 0, 16'h0101, 1'b1);
    push_px(5, 6, 0, 16'h0202, 1'b1);
    clear_page  = 1'b1;
    clear_color = 16'h0000;
    clear_start = 1'b1;
    tick(1);
    clear_start = 1'b0;
    chk("clear_wr_ready", 36'(wr_ready), 36'd0);
    chk("clear_busy", 36'(busy_out), 36'd1);
    clear_page  = 1'b0;
    clear_color = 16'hFFFF;
    clear_start = 1'b1;
    tick(1);
    clear_start = 1'b0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        exp_addr.push_back(px_addr(1, x, y));
        exp_data.push_back(16'h0000);
      end
    draw_en = 1'b1;
    n0 = 0;
    forever begin
      tick(1);
      if (!busy_out) break;
      n0++;
      if (n0 > 4 * W * H + 100) begin
        chk("clear_timeout", 36'(busy_out), 36'd0);
        break;
      end
    end
    chk("clear_end_ready", 36'(wr_ready), 36'd1);
    tick(3);
    chk("clear_last_addr", 36'(obs_addr[$]), 36'(px_addr(1, W - 1, H - 1)));
    check_log("clear");

    // Reset in the middle of a WRITE
    draw_en = 1'b0;
    push_px(2, 3, 0, 16'hC0DE, 1'b0);
    push_px(4, 5, 1, 16'hCAFE, 1'b0);
    push_px(6, 7, 0, 16'hF00D, 1'b0);
    draw_en = 1'b1;
    n0 = 0;
    forever begin
      tick(1);
      if (sram_we_n == 1'b0) break;
      n0++;
      if (n0 > 20) begin
        chk("rst_we_timeout", 36'(sram_we_n), 36'd0);
        break;
      end
    end
    rst = 1'b1;
    exp_addr.push_back(px_addr(0, 2, 3));
    exp_data.push_back(16'hC0DE);
    chk("oob_still_set", 36'(oob_out), 36'd1);
    tick(1);
    chk("midrst_we_n", 36'(sram_we_n), 36'd1);
    chk("midrst_flags", 36'({busy_out, bus_own_out, wr_ready}), 36'd0);
    rst = 1'b0;
    tick(1);
    chk("midrst_after", 36'({oob_out, busy_out, wr_ready}), 36'b001);
    tick(12);
    chk("midrst_no_writes", 36'({busy_out, bus_own_out}), 36'd0);
    check_log("midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
